merger_2_select: RTL

Front-end selector for the 2-merger. It watches the head words of two sorted input FIFOs (A and B), dequeues the one that must go next, and presents it, one word per cycle, to the 4-input bitonic network together with that network's stall, switch and top-tuple side-band. Each word holds 2 records. It also detects end-of-stream terminators, drains the surviving input, and emits a single terminator per merged run.

---
 rtl/merger_2_select.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/merger_2_select.sv
// Front-end selector for the 2-merger: picks the next word from two sorted FIFOs and
// feeds the bitonic network. Optional run counter enabled by `define MERGER_SELECT_STATS_EN.
module merger_2_select #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [2*DATA_WIDTH-1:0] i_a_data,
    input  logic                    i_a_empty,
    output logic                    o_a_deq,
    input  logic [2*DATA_WIDTH-1:0] i_b_data,
    input  logic                    i_b_empty,
    output logic                    o_b_deq,
    input  logic                    i_out_full,
    output logic [2*DATA_WIDTH-1:0] o_elems,
    output logic [2*DATA_WIDTH-1:0] o_top_tuple,
    output logic                    o_stall,
    output logic                    o_switch_output,
`ifdef MERGER_SELECT_STATS_EN
    output logic [31:0]             o_run_count,
`endif
    output logic                    o_merge_done
);
    localparam int WW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {MERGE, DRAIN_A, DRAIN_B, FLUSH} state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic [KEY_WIDTH-1:0] a_key [2];
    logic [KEY_WIDTH-1:0] b_key [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_keys
            assign a_key[gi] = i_a_data[gi*DATA_WIDTH +: KEY_WIDTH];
            assign b_key[gi] = i_b_data[gi*DATA_WIDTH +: KEY_WIDTH];
        end
    endgenerate

    // Key 0 never occurs in data, so two zero keys mark the end of a stream.
    logic a_term, b_term;
    assign a_term = (a_key[0] == '0) && (a_key[1] == '0);
    assign b_term = (b_key[0] == '0) && (b_key[1] == '0);

    state_t          state_q, state_d;
    logic            last_src_q, last_src_d;
    logic [WW-1:0]   elems_q, elems_d;
    logic [WW-1:0]   top_q, top_d;
    logic            stall_q, stall_d;
    logic            switch_q, switch_d;
    logic            done_q, done_d;
    logic            a_deq, b_deq;
    logic            issue;
    logic            issue_src;
    logic [WW-1:0]   issue_word;
    logic [WW-1:0]   issue_top;

    always_comb begin
        state_d    = state_q;
        a_deq      = 1'b0;
        b_deq      = 1'b0;
        issue      = 1'b0;
        issue_src  = SRC_A;
        issue_word = '0;
        issue_top  = '0;
        done_d     = 1'b0;
        unique case (state_q)
            MERGE: begin
                if (!i_a_empty && !i_b_empty && !i_out_full) begin
                    if (a_term && b_term) begin
                        a_deq   = 1'b1;
                        b_deq   = 1'b1;
                        state_d = FLUSH;
                    end else if (a_term) begin
                        a_deq   = 1'b1;
                        state_d = DRAIN_B;
                    end else if (b_term) begin
                        b_deq   = 1'b1;
                        state_d = DRAIN_A;
                    end else if (a_key[1] <= b_key[1]) begin
                        a_deq      = 1'b1;
                        issue      = 1'b1;
                        issue_src  = SRC_A;
                        issue_word = i_a_data;
                        issue_top  = i_b_data;
                    end else begin
                        b_deq      = 1'b1;
                        issue      = 1'b1;
                        issue_src  = SRC_B;
                        issue_word = i_b_data;
                        issue_top  = i_a_data;
                    end
                end
            end
            DRAIN_A: begin
                if (!i_a_empty && !i_out_full) begin
                    a_deq = 1'b1;
                    if (a_term) begin
                        state_d = FLUSH;
                    end else begin
                        issue      = 1'b1;
                        issue_src  = SRC_A;
                        issue_word = i_a_data;
                    end
                end
            end
            DRAIN_B: begin
                if (!i_b_empty && !i_out_full) begin
                    b_deq = 1'b1;
                    if (b_term) begin
                        state_d = FLUSH;
                    end else begin
                        issue      = 1'b1;
                        issue_src  = SRC_B;
                        issue_word = i_b_data;
                    end
                end
            end
            default: begin
                if (!i_out_full) begin
                    issue     = 1'b1;
                    issue_src = SRC_A;
                    done_d    = 1'b1;
                    state_d   = MERGE;
                end
            end
        endcase
    end

    // Output registers hold their value on cycles with nothing to issue.
    always_comb begin
        elems_d    = elems_q;
        top_d      = top_q;
        switch_d   = switch_q;
        last_src_d = last_src_q;
        stall_d    = 1'b1;
        if (issue) begin
            elems_d    = issue_word;
            top_d      = issue_top;
            switch_d   = (issue_src != last_src_q);
            last_src_d = issue_src;
            stall_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= MERGE;
            last_src_q <= SRC_A;
            elems_q    <= '0;
            top_q      <= '0;
            stall_q    <= 1'b1;
            switch_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            elems_q    <= elems_d;
            top_q      <= top_d;
            stall_q    <= stall_d;
            switch_q   <= switch_d;
            done_q     <= done_d;
        end
    end

`ifdef MERGER_SELECT_STATS_EN
    logic [31:0] run_count_q, run_count_d;

    // The terminator itself is not counted; the count restarts after the done pulse.
    always_comb begin
        run_count_d = (done_q ? 32'd0 : run_count_q) + 32'(issue && !done_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_count_q <= '0;
        end else begin
            run_count_q <= run_count_d;
        end
    end

    assign o_run_count = run_count_q;
`endif

    assign o_a_deq         = a_deq & ~i_rst;
    assign o_b_deq         = b_deq & ~i_rst;
    assign o_elems         = elems_q;
    assign o_top_tuple     = top_q;
    assign o_stall         = stall_q;
    assign o_switch_output = switch_q;
    assign o_merge_done    = done_q;
endmodule
